// File: rtl/if_prefetch.sv
// Instruction fetch prefetch queue: in-order word requests to instruction memory,
// {pc, instr} buffering in a DEPTH-entry FIFO, and redirect flush with stale-response discard.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   resp_pc, resp_pc_n;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] outstanding, out_n;
  logic [CW-1:0] discard, discard_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic          req_q, req_n;
  logic          valid_q;
  logic [31:0]   head_pc_q, head_pc_n;
  logic [31:0]   head_instr_q, head_instr_n;

  logic          gnt_fire, rv_ok, drop, push, pop;
  logic [31:0]   redir_pc;

  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = valid_q;
  assign instr_o       = head_instr_q;
  assign instr_pc_o    = head_pc_q;

  assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Next-cycle datapath: handshakes, credits, FIFO pointers and registered head
  always_comb begin
    gnt_fire     = req_q & imem_gnt_i;
    rv_ok        = imem_rvalid_i && (outstanding != '0);
    out_n        = outstanding + CW'(gnt_fire) - CW'(rv_ok);
    drop         = rv_ok && (discard != '0);
    push         = rv_ok && (discard == '0) && !redirect_i;
    pop          = valid_q && instr_ready_i && !redirect_i;

    count_n      = count;
    rd_ptr_n     = rd_ptr;
    wr_ptr_n     = wr_ptr;
    discard_n    = discard;
    fetch_pc_n   = fetch_pc;
    resp_pc_n    = resp_pc;
    head_pc_n    = head_pc_q;
    head_instr_n = head_instr_q;

    if (redirect_i) begin
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      discard_n  = out_n;
      fetch_pc_n = redir_pc;
      resp_pc_n  = redir_pc;
    end else begin
      count_n   = count + CW'(push) - CW'(pop);
      wr_ptr_n  = wr_ptr + AW'(push);
      rd_ptr_n  = rd_ptr + AW'(pop);
      discard_n = discard - CW'(drop);
      if (gnt_fire) fetch_pc_n = fetch_pc + 32'd4;
      if (push)     resp_pc_n  = resp_pc + 32'd4;
      // A push landing exactly at the new head bypasses the storage array
      if (push && (wr_ptr == rd_ptr_n)) begin
        head_pc_n    = resp_pc;
        head_instr_n = imem_rdata_i;
      end else begin
        head_pc_n    = mem_pc[rd_ptr_n];
        head_instr_n = mem_instr[rd_ptr_n];
      end
    end

    req_n = (SW'(count_n) + SW'(out_n)) < SW'(DEPTH);
  end

  // FSM, counters, pointers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      count        <= '0;
      outstanding  <= '0;
      discard      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      head_pc_q    <= 32'h0;
      head_instr_q <= 32'h0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (redirect_i && (out_n != '0)) state <= DRAIN;
        DRAIN: begin
          if (redirect_i) state <= (out_n != '0) ? DRAIN : RUN;
          else if (discard_n == '0) state <= RUN;
        end
        default: state <= BOOT;
      endcase
      fetch_pc     <= fetch_pc_n;
      resp_pc      <= resp_pc_n;
      count        <= count_n;
      outstanding  <= out_n;
      discard      <= discard_n;
      rd_ptr       <= rd_ptr_n;
      wr_ptr       <= wr_ptr_n;
      // Every state reachable after a clock edge is a fetching state
      req_q        <= req_n;
      valid_q      <= (count_n != '0);
      head_pc_q    <= head_pc_n;
      head_instr_q <= head_instr_n;
    end
  end

  // FIFO storage; only entries behind the registered head are read back
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_ptr]    <= resp_pc;
      mem_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  // Memory must not return more responses than were granted
  a_rvalid_has_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outstanding != '0)
  ) else $error("if_prefetch: rvalid with no outstanding request");

endmodule
